// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/PC-select control and mult/div sequencer
module pipe_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int TIMER_W    = 7
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       load_use_i,
    input  logic       fd_jump_i,
    input  logic       dx_mispredict_i,
    input  logic       dx_md_op_i,
    input  logic       md_ready_i,
    output logic       stall_o,
    output logic       hold_dx_o,
    output logic       flush_fd_o,
    output logic       flush_dx_o,
    output logic [1:0] pc_sel_o,
    output logic       md_start_o,
    output logic       md_wb_o,
    output logic       md_error_o,
    output logic       mispredict_o
);

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_JUMP = 2'd1;
    localparam logic [1:0] PC_FIX  = 2'd2;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MD_TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               md_ok_q, md_ok_d;
    logic               md_error_q, md_error_d;
    logic               md_busy;

    // md_ok_q remembers whether MD_DONE was reached through md_ready, gating writeback.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        md_ok_d    = md_ok_q;
        md_error_d = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (dx_md_op_i && !dx_mispredict_i) begin
                    state_d = MD_RUN;
                    timer_d = '0;
                    md_ok_d = 1'b0;
                end
            end
            MD_RUN: begin
                if (md_ready_i) begin
                    state_d = MD_DONE;
                    md_ok_d = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d    = MD_DONE;
                    md_ok_d    = 1'b0;
                    md_error_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= MD_IDLE;
            timer_q    <= '0;
            md_ok_q    <= 1'b0;
            md_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            md_ok_q    <= md_ok_d;
            md_error_q <= md_error_d;
        end
    end

    assign md_busy = ((state_q == MD_IDLE) && dx_md_op_i) || (state_q == MD_RUN);

    // Mispredict outranks everything: FD holds wrong-path work, so no stall is useful.
    always_comb begin
        stall_o      = 1'b0;
        hold_dx_o    = 1'b0;
        flush_fd_o   = 1'b0;
        flush_dx_o   = 1'b0;
        pc_sel_o     = PC_SEQ;
        md_start_o   = 1'b0;
        mispredict_o = 1'b0;
        if (!reset_i) begin
            if (dx_mispredict_i) begin
                flush_fd_o   = 1'b1;
                flush_dx_o   = 1'b1;
                pc_sel_o     = PC_FIX;
                mispredict_o = 1'b1;
            end else if (md_busy) begin
                stall_o    = 1'b1;
                hold_dx_o  = 1'b1;
                md_start_o = (state_q == MD_IDLE);
            end else if ((state_q == MD_IDLE) && load_use_i) begin
                stall_o    = 1'b1;
                flush_dx_o = 1'b1;
            end else if (fd_jump_i) begin
                flush_fd_o = 1'b1;
                pc_sel_o   = PC_JUMP;
            end
        end
    end

    assign md_wb_o    = !reset_i && (state_q == MD_DONE) && md_ok_q;
    assign md_error_o = !reset_i && md_error_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table plus randomized reference-model bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic       clock, reset, load_use, fd_jump, dx_mispredict, dx_md_op, md_ready;
    logic       stall, hold_dx, flush_fd, flush_dx, md_start, md_wb, md_error, mispredict;
    logic [1:0] pc_sel;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.MD_TIMEOUT(TO), .TIMER_W(3)) dut (
        .clock_i(clock), .reset_i(reset), .load_use_i(load_use), .fd_jump_i(fd_jump),
        .dx_mispredict_i(dx_mispredict), .dx_md_op_i(dx_md_op), .md_ready_i(md_ready),
        .stall_o(stall), .hold_dx_o(hold_dx), .flush_fd_o(flush_fd), .flush_dx_o(flush_dx),
        .pc_sel_o(pc_sel), .md_start_o(md_start), .md_wb_o(md_wb), .md_error_o(md_error),
        .mispredict_o(mispredict)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // inputs: {reset, load_use, fd_jump, dx_mispredict, dx_md_op, md_ready}
    // outputs: {stall, hold_dx, flush_fd, flush_dx, pc_sel[1:0], md_start, md_wb, md_error, mispredict}
    typedef struct {
        string      name;
        logic [5:0] vin;
        logic [10:0] vexp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string n, input logic [5:0] i, input logic [10:0] e);
        vec_t v;
        v.name = n; v.vin = i; v.vexp = e;
        tbl.push_back(v);
    endfunction

    function automatic logic [10:0] outs();
        return {stall, hold_dx, flush_fd, flush_dx, pc_sel, md_start, md_wb, md_error, mispredict};
    endfunction

    task automatic apply(input logic [5:0] vin);
        @(negedge clock);
        {reset, load_use, fd_jump, dx_mispredict, dx_md_op, md_ready} = vin;
        #2;
    endtask

    task automatic check(input string n, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", n, act, exp);
        end
    endtask

    // Reference model state: what the mult/div sequencer is doing at a high level.
    int  phase;      // 0 waiting for an op, 1 op in flight, 2 finishing cycle
    int  waited;
    bit  finished_ok;
    bit  err_pend;

    function automatic logic [10:0] model_out(input logic [5:0] vin);
        logic rst, lu, fj, mp, op, rdy;
        logic s, h, ffd, fdx, st, wb, er, mi;
        logic [1:0] pc;
        {rst, lu, fj, mp, op, rdy} = vin;
        {s, h, ffd, fdx, st, wb, er, mi} = '0;
        pc = 2'd0;
        if (!rst) begin
            if (mp) begin
                ffd = 1; fdx = 1; pc = 2'd2; mi = 1;
            end else if ((phase == 0 && op) || phase == 1) begin
                s = 1; h = 1; st = (phase == 0);
            end else if (phase == 0 && lu) begin
                s = 1; fdx = 1;
            end else if (fj) begin
                ffd = 1; pc = 2'd1;
            end
            wb = (phase == 2) && finished_ok;
            er = err_pend;
        end
        return {s, h, ffd, fdx, pc, st, wb, er, mi};
    endfunction

    task automatic model_step(input logic [5:0] vin);
        logic rst, lu, fj, mp, op, rdy;
        bit new_err;
        {rst, lu, fj, mp, op, rdy} = vin;
        new_err = 0;
        if (rst) begin
            phase = 0; waited = 0; finished_ok = 0;
        end else if (phase == 0) begin
            if (op && !mp) begin phase = 1; waited = 0; end
        end else if (phase == 1) begin
            if (rdy) begin
                phase = 2; finished_ok = 1;
            end else if (waited == TO - 1) begin
                phase = 2; finished_ok = 0; new_err = 1;
            end else begin
                waited++;
            end
        end else begin
            phase = 0;
        end
        err_pend = new_err;
    endtask

    initial begin
        {reset, load_use, fd_jump, dx_mispredict, dx_md_op, md_ready} = 6'b100000;

        add("rst0",        6'b111111, 11'b0000_00_0000);
        add("rst1",        6'b111111, 11'b0000_00_0000);
        add("idle",        6'b000000, 11'b0000_00_0000);
        add("hp_c0",       6'b000010, 11'b1100_00_1000);
        add("hp_c1",       6'b000010, 11'b1100_00_0000);
        add("hp_c2",       6'b000010, 11'b1100_00_0000);
        add("hp_c3",       6'b000010, 11'b1100_00_0000);
        add("hp_c4",       6'b000011, 11'b1100_00_0000);
        add("hp_c5_wb",    6'b000010, 11'b0000_00_0100);
        add("hp_c6",       6'b000000, 11'b0000_00_0000);
        add("to_c0",       6'b000010, 11'b1100_00_1000);
        add("to_c1",       6'b000010, 11'b1100_00_0000);
        add("to_c2",       6'b000010, 11'b1100_00_0000);
        add("to_c3",       6'b000010, 11'b1100_00_0000);
        add("to_c4",       6'b000010, 11'b1100_00_0000);
        add("to_c5_err",   6'b000010, 11'b0000_00_0010);
        add("to_c6_rdyign",6'b000001, 11'b0000_00_0000);
        add("simul",       6'b011100, 11'b0011_10_0001);
        add("simul_jump",  6'b001000, 11'b0010_01_0000);
        add("load_use",    6'b010000, 11'b1001_00_0000);
        add("lu_jump",     6'b011000, 11'b1001_00_0000);
        add("mp_and_op",   6'b000110, 11'b0011_10_0001);
        add("mp_op_idle",  6'b000000, 11'b0000_00_0000);
        add("jd_c0",       6'b000010, 11'b1100_00_1000);
        add("jd_c1",       6'b001010, 11'b1100_00_0000);
        add("jd_c2",       6'b001010, 11'b1100_00_0000);
        add("jd_c3",       6'b001011, 11'b1100_00_0000);
        add("jd_done",     6'b001010, 11'b0010_01_0100);
        add("jd_idle",     6'b000000, 11'b0000_00_0000);
        add("rm_c0",       6'b000010, 11'b1100_00_1000);
        add("rm_c1",       6'b000010, 11'b1100_00_0000);
        add("rm_rst",      6'b100010, 11'b0000_00_0000);
        add("rm_silent",   6'b000001, 11'b0000_00_0000);
        add("rm_restart",  6'b000010, 11'b1100_00_1000);
        add("rm_run",      6'b000011, 11'b1100_00_0000);
        add("rm_wb",       6'b000000, 11'b0000_00_0100);
        add("rm_idle",     6'b000000, 11'b0000_00_0000);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].vin);
            check(tbl[i].name, outs(), tbl[i].vexp);
        end

        phase = 0; waited = 0; finished_ok = 0; err_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] vin;
            vin[5] = ($urandom_range(0, 39) == 0);
            vin[4] = ($urandom_range(0, 3) == 0);
            vin[3] = ($urandom_range(0, 2) == 0);
            vin[2] = ($urandom_range(0, 9) == 0);
            vin[1] = ($urandom_range(0, 2) == 0);
            vin[0] = ($urandom_range(0, 4) == 0);
            apply(vin);
            check($sformatf("rand%0d_in%b", i, vin), outs(), model_out(vin));
            model_step(vin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
